// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants and FSM state encoding for the serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DEF_WIDTH / DEF_DIGIT defaults, state_t {IDLE, CALC, DONE}.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result handshake bundle for serial_sub.
// Latency: n/a (wires only).
// Backpressure: in_ready gates operand acceptance, out_ready releases the held result.
// Signals: in_valid/in_ready/a/b/c (operand side), out_valid/out_ready/out (result side).
//   master = producer/consumer environment, slave = serial_sub.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/serial_sub_digit.sv
// sub_digit: combinational DIGIT-bit subtractor slice with borrow chaining.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (DIGIT-bit operands), bin (borrow-in), res = {borrow-out, diff}.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT:0]   res
);

  // One extra bit of headroom: the top bit of the result is the sign of
  // a - b - bin, which is exactly the borrow-out of this slice.
  assign res = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};

endmodule

// File: rtl/serial_sub.sv
// serial_sub: digit-serial a - b - c, one DIGIT slice per cycle, LSB first.
// Latency: out_valid rises WIDTH/DIGIT+1 edges after the accepting edge.
// Backpressure: single operation in flight; result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), io (serial_sub_if.slave):
//   in_valid/in_ready/a/b/c in, out_valid/out_ready/out = {borrow, diff} out.
// Build option: SERIAL_SUB_SAT_EN clamps the difference to 0 when borrow-out is set.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input logic        clk,
  input logic        rst_n,
  serial_sub_if.slave io
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic             bor_r;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dig_res;
  logic [WIDTH-1:0] diff_nx;
  logic [WIDTH-1:0] res_val;

  // Single slice reused every CALC cycle; operands shift right so the
  // current digit always sits in the low DIGIT bits.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (a_r[DIGIT-1:0]),
    .b   (b_r[DIGIT-1:0]),
    .bin (bor_r),
    .res (dig_res)
  );

  // Result digits enter at the top and shift down, so after NDIG steps
  // the least-significant digit computed first lands in bit 0.
  always_comb begin
    diff_nx                   = diff_r >> DIGIT;
    diff_nx[WIDTH-1 -: DIGIT] = dig_res[DIGIT-1:0];
  end

  always_comb begin
`ifdef SERIAL_SUB_SAT_EN
    res_val = bor_r ? '0 : diff_r;
`else
    res_val = diff_r;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      diff_r       <= '0;
      bor_r        <= 1'b0;
      cnt          <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_r         <= io.a;
            b_r         <= io.b;
            bor_r       <= io.c;
            diff_r      <= '0;
            cnt         <= '0;
            io.in_ready <= 1'b0;
            state       <= CALC;
          end
        end
        CALC: begin
          if (cnt != CW'(NDIG)) begin
            a_r    <= a_r >> DIGIT;
            b_r    <= b_r >> DIGIT;
            diff_r <= diff_nx;
            bor_r  <= dig_res[DIGIT];
            cnt    <= cnt + 1'b1;
          end else begin
            // All digits done: final borrow and difference are registered
            // onto the output together with out_valid.
            io.out_valid <= 1'b1;
            io.out       <= {bor_r, res_val};
            state        <= DONE;
          end
        end
        DONE: begin
          // in_ready only rises once back in IDLE, so a result consumed
          // this cycle can never overlap a new accept.
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.out       <= '0;
            io.in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          io.in_ready  <= 1'b1;
          io.out_valid <= 1'b0;
          io.out       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed vector table, back-pressure, reset-abort and random checks for serial_sub.
// Latency: expects out_valid 3 edges after accept (WIDTH=8, DIGIT=4).
// Backpressure: holds out_ready low for a chosen number of DONE cycles per operation.
module tb_serial_sub;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  serial_sub_if #(.WIDTH(8)) sif ();

  serial_sub #(.WIDTH(8), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
    logic [8:0] exp_sat;
    int         hold;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] pick(input logic [8:0] plain, input logic [8:0] sat);
`ifdef SERIAL_SUB_SAT_EN
    return sat;
`else
    return plain;
`endif
  endfunction

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'd0, c};
`ifdef SERIAL_SUB_SAT_EN
    if (r[8]) r = 9'h100;
`endif
    return r;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int hold, input logic [8:0] exp, input string nm);
    int  k;
    bit  got;
    logic [8:0] held;
    k = 0;
    while (!sif.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, " in_ready idle"}, 32'(sif.in_ready), 32'd1);
    sif.in_valid = 1'b1;
    sif.a = a;
    sif.b = b;
    sif.c = c;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    check({nm, " in_ready busy"}, 32'(sif.in_ready), 32'd0);
    got = 1'b0;
    k   = 0;
    while (!got && k < 20) begin
      // Scramble operands while the operation is in flight.
      sif.a = 8'($urandom);
      sif.b = 8'($urandom);
      sif.c = 1'($urandom);
      @(posedge clk); #1;
      k++;
      if (sif.out_valid) got = 1'b1;
      else check({nm, " out zero while busy"}, 32'(sif.out), 32'd0);
    end
    check({nm, " latency"}, 32'(k), 32'd3);
    check({nm, " result"}, 32'(sif.out), 32'(exp));
    held = sif.out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({nm, " held valid"}, 32'(sif.out_valid), 32'd1);
      check({nm, " held out"}, 32'(sif.out), 32'(held));
      check({nm, " held in_ready"}, 32'(sif.in_ready), 32'd0);
    end
    // Offer a new operand in the consume cycle: it must not be taken.
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b0;
    check({nm, " consumed valid"}, 32'(sif.out_valid), 32'd0);
    check({nm, " consumed out"}, 32'(sif.out), 32'd0);
    check({nm, " in_ready after"}, 32'(sif.in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         bad;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 9'h023, 9'h023, 0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 9'h1FF, 9'h100, 1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 9'h000, 9'h000, 0};
    vecs[3] = '{8'hF0, 8'h0F, 1'b0, 9'h0E1, 9'h0E1, 5};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 9'h00F, 9'h00F, 2};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h100, 0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 9'h1FF, 9'h100, 3};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 9'h0FF, 9'h0FF, 0};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 9'h1DE, 9'h100, 1};
    vecs[9] = '{8'hA5, 8'h5A, 1'b1, 9'h04A, 9'h04A, 0};

    rst_n         = 1'b0;
    sif.in_valid  = 1'b0;
    sif.a         = '0;
    sif.b         = '0;
    sif.c         = 1'b0;
    sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(sif.in_ready), 32'd1);
    check("reset out_valid", 32'(sif.out_valid), 32'd0);
    check("reset out", 32'(sif.out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold,
             pick(vecs[i].exp, vecs[i].exp_sat), $sformatf("vec%0d", i));

    // Reset asserted during the second CALC cycle aborts the operation.
    sif.in_valid = 1'b1;
    sif.a = 8'h35;
    sif.b = 8'h12;
    sif.c = 1'b0;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(sif.in_ready), 32'd1);
    check("abort out_valid", 32'(sif.out_valid), 32'd0);
    check("abort out", 32'(sif.out), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (sif.out_valid || !sif.in_ready) bad++;
    end
    check("abort no result", 32'(bad), 32'd0);
    run_op(8'h10, 8'h01, 1'b0, 0, 9'h00F, "post-reset");

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), model(ra, rb, rc),
             $sformatf("rand%0d a=%0h b=%0h c=%0d", n, ra, rb, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
